// File: rtl/bht_branch_predictor.sv
// Branch direction predictor: table of 2-bit saturating counters with branch/miss statistics.
// Optional gshare indexing is enabled by defining GSHARE_EN.
module bht_branch_predictor #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 30,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [ADDR_W-1:0] if_pc,
  output logic [IDX_W-1:0]  if_idx,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [IDX_W-1:0]  ex_idx,
  input  logic              ex_taken,
  input  logic              ex_pred_taken,
  output logic              branch,
  output logic              correct,
  output logic              flush,
  output logic [CNT_W-1:0]  cnt_branch,
  output logic [CNT_W-1:0]  cnt_miss
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [1:0] sat_step2(input logic [1:0] cur, input logic up);
    logic [1:0] nxt;
    case ({up, cur})
      3'b1_00: nxt = 2'b01;
      3'b1_01: nxt = 2'b10;
      3'b1_10: nxt = 2'b11;
      3'b1_11: nxt = 2'b11;
      3'b0_00: nxt = 2'b00;
      3'b0_01: nxt = 2'b00;
      3'b0_10: nxt = 2'b01;
      3'b0_11: nxt = 2'b10;
      default: nxt = WN;
    endcase
    return nxt;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  logic [1:0]       bht_r [ENTRIES];
  logic [1:0]       upd_val_s;
  logic             upd_en_s;
  logic [IDX_W-1:0] idx_s;
  logic             unused_pc_s;

  // Upper PC bits do not participate in indexing.
  assign unused_pc_s = ^if_pc[ADDR_W-1:IDX_W];
  assign upd_en_s    = ex_valid & ~stall;

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr_r;

  // Global history shifts in each resolved outcome alongside the BHT update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_r <= {IDX_W{1'b0}};
    end else if (upd_en_s) begin
      ghr_r <= {ghr_r[IDX_W-2:0], ex_taken};
    end else begin
      ghr_r <= ghr_r;
    end
  end

  assign idx_s = if_pc[IDX_W-1:0] ^ ghr_r;
`else
  assign idx_s = if_pc[IDX_W-1:0];
`endif

  assign if_idx     = idx_s;
  assign pred_taken = bht_r[idx_s][1];

  // Next value of the counter being trained.
  always_comb begin
    upd_val_s = sat_step2(bht_r[ex_idx], ex_taken);
  end

  // Counter table: full re-init on reset, single-entry update otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_r[i] <= WN;
      end
    end else if (upd_en_s) begin
      bht_r[ex_idx] <= upd_val_s;
    end else begin
      bht_r[ex_idx] <= bht_r[ex_idx];
    end
  end

  // Status is purely a function of the EX inputs; idle EX reads as correct.
  always_comb begin
    branch  = ex_valid;
    correct = ~(ex_valid & (ex_taken != ex_pred_taken));
    flush   = ~correct & ~stall;
  end

  // Saturating statistics, frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branch <= {CNT_W{1'b0}};
      cnt_miss   <= {CNT_W{1'b0}};
    end else if (!stall) begin
      if (ex_valid) begin
        cnt_branch <= sat_inc_cnt(cnt_branch);
      end else begin
        cnt_branch <= cnt_branch;
      end
      if (!correct) begin
        cnt_miss <= sat_inc_cnt(cnt_miss);
      end else begin
        cnt_miss <= cnt_miss;
      end
    end else begin
      cnt_branch <= cnt_branch;
      cnt_miss   <= cnt_miss;
    end
  end

endmodule

// File: tb/tb_bht_branch_predictor.sv
// Directed self-checking bench for bht_branch_predictor (default build; gshare test when GSHARE_EN is defined).
module tb_bht_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [29:0] if_pc;
  logic [3:0]  if_idx;
  logic        pred_taken;
  logic        ex_valid;
  logic [3:0]  ex_idx;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic        branch;
  logic        correct;
  logic        flush;
  logic [15:0] cnt_branch;
  logic [15:0] cnt_miss;

  int tests_run = 0;
  int fails = 0;

  bht_branch_predictor dut (
    .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc), .if_idx(if_idx),
    .pred_taken(pred_taken), .ex_valid(ex_valid), .ex_idx(ex_idx),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .branch(branch),
    .correct(correct), .flush(flush), .cnt_branch(cnt_branch), .cnt_miss(cnt_miss)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; if_pc = 30'h0; ex_valid = 1'b0;
    ex_idx = 4'h0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
    tick(3);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      if_pc = 30'h3A0 | 30'(i);
      #1;
      tests_run++;
      if (pred_taken !== 1'b0) begin
        fails++; $display("FAIL reset_pred idx=%0d got=%b exp=0", i, pred_taken);
      end
      tests_run++;
      if (if_idx !== 4'(i)) begin
        fails++; $display("FAIL reset_if_idx got=%h exp=%h", if_idx, 4'(i));
      end
    end
    tests_run++;
    if (cnt_branch !== 16'h0 || cnt_miss !== 16'h0) begin
      fails++; $display("FAIL reset_stats got=%h/%h exp=0000/0000", cnt_branch, cnt_miss);
    end
    tests_run++;
    if (branch !== 1'b0 || correct !== 1'b1 || flush !== 1'b0) begin
      fails++; $display("FAIL reset_status got b=%b c=%b f=%b exp 0 1 0", branch, correct, flush);
    end
  endtask

  task automatic test_taken_train();
    if_pc = 30'h4; ex_valid = 1'b1; ex_idx = 4'h4; ex_taken = 1'b1; ex_pred_taken = 1'b1;
    #1;
    tests_run++;
    if (pred_taken !== 1'b0) begin
      fails++; $display("FAIL no_bypass got=%b exp=0", pred_taken);
    end
    tick(1);
    tests_run++;
    if (pred_taken !== 1'b1) begin
      fails++; $display("FAIL taken_1 got=%b exp=1", pred_taken);
    end
    tick(1);
    tests_run++;
    if (pred_taken !== 1'b1 || cnt_branch !== 16'd2 || cnt_miss !== 16'd0) begin
      fails++; $display("FAIL taken_2 got p=%b %0d/%0d exp p=1 2/0", pred_taken, cnt_branch, cnt_miss);
    end
  endtask

  task automatic test_not_taken_train();
    ex_taken = 1'b0; ex_pred_taken = 1'b1;
    tick(1);
    tests_run++;
    if (pred_taken !== 1'b1 || cnt_miss !== 16'd1) begin
      fails++; $display("FAIL nt_1 got p=%b miss=%0d exp p=1 miss=1", pred_taken, cnt_miss);
    end
    tick(1);
    tests_run++;
    if (pred_taken !== 1'b0 || cnt_branch !== 16'd4 || cnt_miss !== 16'd2) begin
      fails++; $display("FAIL nt_2 got p=%b %0d/%0d exp p=0 4/2", pred_taken, cnt_branch, cnt_miss);
    end
    // Entry should be at 01: a single taken update must flip the prediction.
    ex_taken = 1'b1;
    tick(1);
    tests_run++;
    if (pred_taken !== 1'b1 || cnt_branch !== 16'd5 || cnt_miss !== 16'd2) begin
      fails++; $display("FAIL nt_retrain got p=%b %0d/%0d exp p=1 5/2", pred_taken, cnt_branch, cnt_miss);
    end
    ex_valid = 1'b0; ex_taken = 1'b1; ex_pred_taken = 1'b0;
    #1;
    tests_run++;
    if (correct !== 1'b1 || flush !== 1'b0 || branch !== 1'b0) begin
      fails++; $display("FAIL idle_correct got c=%b f=%b b=%b exp 1 0 0", correct, flush, branch);
    end
    tick(2);
    tests_run++;
    if (cnt_branch !== 16'd5 || cnt_miss !== 16'd2 || pred_taken !== 1'b1) begin
      fails++; $display("FAIL idle_hold got %0d/%0d p=%b exp 5/2 p=1", cnt_branch, cnt_miss, pred_taken);
    end
  endtask

  task automatic test_miss_stall();
    if_pc = 30'h7; ex_valid = 1'b1; ex_idx = 4'h7; ex_taken = 1'b1; ex_pred_taken = 1'b0; stall = 1'b0;
    #1;
    tests_run++;
    if (correct !== 1'b0 || flush !== 1'b1 || branch !== 1'b1) begin
      fails++; $display("FAIL miss_status got c=%b f=%b b=%b exp 0 1 1", correct, flush, branch);
    end
    tick(1);
    tests_run++;
    if (cnt_branch !== 16'd6 || cnt_miss !== 16'd3 || pred_taken !== 1'b1) begin
      fails++; $display("FAIL miss_count got %0d/%0d p=%b exp 6/3 p=1", cnt_branch, cnt_miss, pred_taken);
    end
    if_pc = 30'h9; ex_idx = 4'h9; stall = 1'b1;
    #1;
    tests_run++;
    if (flush !== 1'b0 || correct !== 1'b0) begin
      fails++; $display("FAIL stall_status got f=%b c=%b exp 0 0", flush, correct);
    end
    tick(3);
    tests_run++;
    if (cnt_branch !== 16'd6 || cnt_miss !== 16'd3 || pred_taken !== 1'b0) begin
      fails++; $display("FAIL stall_hold got %0d/%0d p=%b exp 6/3 p=0", cnt_branch, cnt_miss, pred_taken);
    end
    stall = 1'b0;
    tick(1);
    ex_valid = 1'b0;
    tests_run++;
    if (cnt_branch !== 16'd7 || cnt_miss !== 16'd4 || pred_taken !== 1'b1) begin
      fails++; $display("FAIL stall_release got %0d/%0d p=%b exp 7/4 p=1", cnt_branch, cnt_miss, pred_taken);
    end
  endtask

  task automatic test_saturate_and_reset();
    if_pc = 30'h2; ex_valid = 1'b1; ex_idx = 4'h2; ex_taken = 1'b1; ex_pred_taken = 1'b0;
    tick(65535);
    tests_run++;
    if (cnt_branch !== 16'hFFFF || cnt_miss !== 16'hFFFF) begin
      fails++; $display("FAIL stats_saturate got %h/%h exp ffff/ffff", cnt_branch, cnt_miss);
    end
    tick(2);
    tests_run++;
    if (cnt_branch !== 16'hFFFF || cnt_miss !== 16'hFFFF || pred_taken !== 1'b1) begin
      fails++; $display("FAIL stats_hold got %h/%h p=%b exp ffff/ffff p=1", cnt_branch, cnt_miss, pred_taken);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0; ex_valid = 1'b0;
    #1;
    tests_run++;
    if (cnt_branch !== 16'h0 || cnt_miss !== 16'h0 || pred_taken !== 1'b0) begin
      fails++; $display("FAIL midrun_reset got %h/%h p=%b exp 0000/0000 p=0", cnt_branch, cnt_miss, pred_taken);
    end
    for (int i = 4; i < 10; i++) begin
      if_pc = 30'(i);
      #1;
      tests_run++;
      if (pred_taken !== 1'b0) begin
        fails++; $display("FAIL midrun_reset_entry idx=%0d got=%b exp=0", i, pred_taken);
      end
    end
    // Entry 2 must be 01, not 00: one taken update sets prediction.
    if_pc = 30'h2; ex_valid = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b1;
    tick(1);
    ex_valid = 1'b0;
    tests_run++;
    if (pred_taken !== 1'b1 || cnt_branch !== 16'd1 || cnt_miss !== 16'd0) begin
      fails++; $display("FAIL post_reset_train got p=%b %0d/%0d exp p=1 1/0", pred_taken, cnt_branch, cnt_miss);
    end
  endtask

`ifdef GSHARE_EN
  task automatic test_gshare();
    rst = 1'b1; ex_valid = 1'b0;
    tick(1);
    rst = 1'b0; ex_valid = 1'b1; ex_idx = 4'h0; ex_taken = 1'b1; ex_pred_taken = 1'b1;
    tick(2);
    ex_valid = 1'b0; if_pc = 30'h5;
    #1;
    tests_run++;
    if (if_idx !== 4'h6) begin
      fails++; $display("FAIL gshare_idx got=%h exp=6", if_idx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_taken_train();
    test_not_taken_train();
    test_miss_stall();
    test_saturate_and_reset();
`ifdef GSHARE_EN
    test_gshare();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
